// File: rtl/max_scan_if.sv
// max_scan_if: sample-in / result-out handshake bundle for max_scan_ctrl.
interface max_scan_if #(
    parameter int IDX_W = 3
);
    logic             start;
    logic             abort;
    logic             in_valid;
    logic [3:0]       in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       max_value;
    logic [IDX_W-1:0] max_index;
    logic             busy;
    modport master (
        output start, abort, in_valid, in_data, out_ready,
        input  in_ready, out_valid, max_value, max_index, busy
    );
    modport slave (
        input  start, abort, in_valid, in_data, out_ready,
        output in_ready, out_valid, max_value, max_index, busy
    );
endinterface

// File: rtl/max_scan_ctrl.sv
// max_scan_ctrl: scans a frame of COUNT 4-bit samples for the maximum and its first index.
module max_scan_ctrl #(
    parameter int COUNT = 8,
    parameter int IDX_W = 3
) (
    input logic      clk,
    input logic      reset,
    max_scan_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    localparam logic [IDX_W:0] LAST = (IDX_W+1)'(COUNT - 1);
    state_t           r_state;
    logic [IDX_W:0]   r_count;
    logic [3:0]       r_max;
    logic [IDX_W-1:0] r_idx;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic             w_take;
    // strict compare keeps the earliest index on ties; first sample always loads
    assign w_take = (r_count == '0) || (bus.in_data > r_max);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_max       <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (bus.abort) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_state    <= ACCUM;
                    r_count    <= '0;
                    r_max      <= '0;
                    r_idx      <= '0;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b1;
                end
                ACCUM: if (bus.in_valid) begin
                    r_count <= r_count + 1'b1;
                    if (w_take) begin
                        r_max <= bus.in_data;
                        r_idx <= r_count[IDX_W-1:0];
                    end
                    if (r_count == LAST) begin
                        r_state     <= DONE;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.max_value = r_max;
    assign bus.max_index = r_idx;
endmodule

// File: tb/tb_max_scan_ctrl.sv
// tb_max_scan_ctrl: table-driven and randomized frames checked against a max/first-index model.
module tb_max_scan_ctrl;
    localparam int COUNT = 8;
    localparam int IDX_W = 3;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int failures = 0;
    logic [0:COUNT-1][3:0] smp;
    typedef struct {
        logic [0:COUNT-1][3:0] s;
        int m;
        int idx;
    } vec_t;
    vec_t tbl [7];
    max_scan_if #(.IDX_W(IDX_W)) bus ();
    max_scan_ctrl #(.COUNT(COUNT), .IDX_W(IDX_W)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic flags(input string nm, input int exp);
        chk(nm, int'({bus.in_ready, bus.out_valid, bus.busy}), exp);
    endtask
    function automatic void ref_model(input int n, output int m, output int idx);
        m = 0;
        idx = 0;
        for (int i = 0; i < n; i++) if (int'(smp[i]) > m) m = int'(smp[i]);
        for (int i = n - 1; i >= 0; i--) if (int'(smp[i]) == m) idx = i;
    endfunction
    task automatic feed(input string nm, input int n, input bit gaps);
        int i = 0;
        int cyc = 0;
        while (i < n && cyc < 200) begin
            bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_data = smp[i];
            flags({nm, " accum"}, 3'b101);
            tick();
            if (bus.in_valid) i++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk({nm, " accepts"}, i, n);
    endtask
    task automatic run_frame(input string nm, input bit gaps, input int stall, input bit bad, input int em, input int ei);
        int i = 0;
        int cyc = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        while (i < COUNT && cyc < 200) begin
            bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_data = smp[i];
            bus.start = bad && i == 3;
            flags({nm, " accum"}, 3'b101);
            tick();
            if (bus.in_valid) i++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.start = 1'b0;
        chk({nm, " accepts"}, i, COUNT);
        flags({nm, " done"}, 3'b011);
        for (int s = 0; s < stall; s++) begin
            bus.start = bad && s == 0;
            chk({nm, " stall max"}, int'(bus.max_value), em);
            chk({nm, " stall idx"}, int'(bus.max_index), ei);
            flags({nm, " stall flags"}, 3'b011);
            tick();
        end
        bus.out_ready = 1'b1;
        bus.start = bad;
        chk({nm, " max"}, int'(bus.max_value), em);
        chk({nm, " idx"}, int'(bus.max_index), ei);
        tick();
        bus.out_ready = 1'b0;
        bus.start = 1'b0;
        flags({nm, " idle"}, 3'b000);
    endtask
    initial begin
        int m;
        int idx;
        tbl[0].s = {4'd3, 4'd7, 4'd2, 4'd9, 4'd9, 4'd1, 4'd0, 4'd4};    tbl[0].m = 9;  tbl[0].idx = 3;
        tbl[1].s = '0;                                                   tbl[1].m = 0;  tbl[1].idx = 0;
        tbl[2].s = {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15};   tbl[2].m = 15; tbl[2].idx = 7;
        tbl[3].s = {COUNT{4'd15}};                                       tbl[3].m = 15; tbl[3].idx = 0;
        tbl[4].s = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};    tbl[4].m = 8;  tbl[4].idx = 7;
        tbl[5].s = {4'd5, 4'd5, 4'd3, 4'd5, 4'd2, 4'd5, 4'd1, 4'd0};    tbl[5].m = 5;  tbl[5].idx = 0;
        tbl[6].s = {4'd2, 4'd4, 4'd6, 4'd8, 4'd8, 4'd6, 4'd4, 4'd2};    tbl[6].m = 8;  tbl[6].idx = 3;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        flags("reset flags", 3'b000);
        chk("reset max", int'(bus.max_value), 0);
        chk("reset idx", int'(bus.max_index), 0);
        reset = 1'b0;
        tick();
        flags("idle no start", 3'b000);
        for (int t = 0; t < 7; t++) begin
            smp = tbl[t].s;
            run_frame($sformatf("tbl%0d", t), 1'b0, 0, 1'b0, tbl[t].m, tbl[t].idx);
        end
        smp = tbl[0].s;
        run_frame("stall_badstart", 1'b1, 5, 1'b1, 9, 3);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        flags("abort+start idle", 3'b000);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        feed("abort5", 5, 1'b0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        flags("abort5 flags", 3'b000);
        chk("abort5 max kept", int'(bus.max_value), 9);
        chk("abort5 idx kept", int'(bus.max_index), 3);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            flags("abort5 ignore", 3'b000);
        end
        bus.in_valid = 1'b0;
        smp = tbl[4].s;
        run_frame("after_abort", 1'b0, 0, 1'b0, 8, 7);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        feed("abort8", COUNT - 1, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data = smp[COUNT-1];
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.in_valid = 1'b0;
        flags("abort8 flags", 3'b000);
        tick();
        flags("abort8 no result", 3'b000);
        smp = tbl[0].s;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        feed("rst mid", 3, 1'b0);
        chk("rst mid max pre", int'(bus.max_value), 7);
        #2 reset = 1'b1;
        #1;
        flags("async rst flags", 3'b000);
        chk("async rst max", int'(bus.max_value), 0);
        chk("async rst idx", int'(bus.max_index), 0);
        tick();
        reset = 1'b0;
        tick();
        flags("post rst idle", 3'b000);
        run_frame("post_rst", 1'b0, 0, 1'b0, 9, 3);
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < COUNT; i++) smp[i] = 4'($urandom_range(0, 15));
            if (r % 4 == 0) for (int i = 0; i < COUNT; i++) smp[i] = 4'($urandom_range(0, 2));
            ref_model(COUNT, m, idx);
            run_frame($sformatf("rand%0d", r), 1'b1, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), m, idx);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/max_scan_ctrl.md
Name: max_scan_ctrl

Overview:
- Sequences a 4-bit "y greater than x" comparison over a frame of COUNT serially delivered samples.
- Returns the frame maximum and the position of its first occurrence.
- Sits between a sample source (switch bank or stimulus FSM) and the display/readout logic.
- Uses a valid/ready handshake on both sides so either neighbour can stall.

Parameters:
- COUNT, 8, samples per frame; legal range 2..16.
- IDX_W, 3, width of the index and sample counter; must satisfy 2^IDX_W >= COUNT.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a frame; honoured only in IDLE.
- abort  input  1  synchronous frame cancel; highest priority after reset.
- in_valid  input  1  in_data holds a sample.
- in_data  input  4  unsigned sample.
- in_ready  output  1  controller accepts a sample this cycle.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- max_value  output  4  frame maximum, unsigned.
- max_index  output  IDX_W  0-based position of the first occurrence of the maximum.
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset values (asynchronous, while reset=1): state=IDLE, count=0, max_value=0, max_index=0, in_ready=0, out_valid=0, busy=0.
- States and transitions:
  - IDLE -> ACCUM when start=1.
  - ACCUM -> DONE on acceptance of sample number COUNT.
  - DONE -> IDLE when out_valid && out_ready.
  - Any state -> IDLE when abort=1.
- All outputs are Moore functions of registered state: in_ready = (state==ACCUM); out_valid = (state==DONE); busy = (state!=IDLE).
- Transfer rule: a sample is accepted on a rising edge where in_valid && in_ready. The result is consumed on an edge where out_valid && out_ready.
- On IDLE->ACCUM: count<=0, max_value<=0, max_index<=0.
- Per accepted sample, with k = count:
  - If k==0: max_value<=in_data, max_index<=0.
  - Else if in_data > max_value (strict unsigned compare): max_value<=in_data, max_index<=k.
  - Else: hold max_value and max_index.
  - Ties keep the earlier index.
  - count<=k+1.
- Cycles where in_valid=0 in ACCUM do not advance count. Idle gaps are unlimited.
- Latency: out_valid rises on the edge after the COUNT-th acceptance. Minimum frame time is 1 start cycle + COUNT accept cycles + 1 result cycle.
- In DONE, max_value and max_index hold stable while out_ready=0, for any number of cycles.
- Back-to-back: start may be asserted in the same cycle as the result handshake, but it is ignored because the state is not yet IDLE. A new frame needs start in IDLE.
- start is ignored in ACCUM and DONE. in_valid is ignored outside ACCUM.
- abort:
  - Sends the block to IDLE on the next edge and drops in_ready/out_valid.
  - max_value and max_index keep their last values until the next start.
  - abort together with start in IDLE: abort wins and the block stays in IDLE.
  - abort on the same edge as the COUNT-th acceptance: abort wins, no result is produced.
- reset mid-frame: immediate return to reset values with no partial result. The first frame after reset needs a fresh start.
- count never exceeds COUNT. No sample is accepted in DONE, so there is no wrap.
- in_data values 0 and 15 are legal. An all-zero frame yields max_value=0, max_index=0.

Test Plan:
- Basic frame, COUNT=8: start, then samples 3,7,2,9,9,1,0,4 with in_valid held high -> in_ready high for exactly 8 cycles; out_valid rises 1 cycle after the 8th acceptance with max_value=9, max_index=3 (tie at index 4 ignored).
- Extremes: frame of all 0 -> max 0, index 0. Frame 0,0,0,0,0,0,0,15 -> max 15, index 7. Frame 15,15,... -> max 15, index 0.
- Stalls: in_valid toggled 1/0 between samples and out_ready held 0 for 5 cycles in DONE -> count advances only on accepts; outputs stay stable for all 5 stall cycles; IDLE follows the out_ready=1 edge.
- Illegal starts: start pulsed in ACCUM after 3 samples and again in DONE -> no restart; the frame completes normally with the correct result.
- Abort: abort after 5 samples, then start and a new frame 1..8 -> out_valid never asserts for the aborted frame; the new frame gives max 8, index 7. Also check abort coincident with the 8th acceptance -> no out_valid.
- Async reset: assert reset between clock edges mid-ACCUM -> all outputs go to 0 immediately, without waiting for a clock edge; a frame after reset release behaves as in the basic-frame scenario.
